// File: rtl/bexkat2_intunit_pkg.sv
// Shared bexkat1 datapath definitions: integer unit function codes
// and the iteration count the control unit waits on.
package bexkat1Def;

  typedef enum logic [3:0] {
    INT_MUL   = 4'd0,
    INT_DIV   = 4'd1,
    INT_MOD   = 4'd2,
    INT_MULU  = 4'd3,
    INT_DIVU  = 4'd4,
    INT_MODU  = 4'd5,
    INT_MULX  = 4'd6,
    INT_MULUX = 4'd7,
    INT_EXT   = 4'd8,
    INT_EXTB  = 4'd9,
    INT_COM   = 4'd10,
    INT_NEG   = 4'd11
  } intfunc_t;

  localparam int INT_ITERS = 32;

  function automatic logic int_iter(input intfunc_t f);
    return f <= INT_MULUX;
  endfunction

  function automatic logic int_mul(input intfunc_t f);
    return f inside {INT_MUL, INT_MULU, INT_MULX, INT_MULUX};
  endfunction

  function automatic logic int_signed(input intfunc_t f);
    return f inside {INT_MUL, INT_DIV, INT_MOD, INT_MULX};
  endfunction

endpackage

// File: rtl/bexkat2_intunit.sv
// bexkat2 iterative integer unit: one-cycle unary ops, 32-step
// shift-add multiply and restoring divide on a shared accumulator.
module bexkat2_intunit
  import bexkat1Def::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       func_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             exc_o
);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t      state, state_n;
  intfunc_t    op, op_n, f;
  logic [63:0] acc, acc_n, prod;
  logic [31:0] opb, opb_n, quo, rem;
  logic [4:0]  cnt, cnt_n;
  logic        neg_q, neg_q_n, neg_r, neg_r_n;
  logic        dz, dz_n, sa, sb;
  logic [31:0] result_n;
  logic        done_n, busy_n, exc_n;
  logic [32:0] sum, trial;

  function automatic logic [31:0] unary(
    input intfunc_t fn,
    input logic [31:0] x
  );
    unique case (fn)
      INT_EXT:  return {{16{x[15]}}, x[15:0]};
      INT_EXTB: return {{24{x[7]}}, x[7:0]};
      INT_COM:  return ~x;
      INT_NEG:  return 32'd0 - x;
      default:  return 32'd0;
    endcase
  endfunction

  assign f = intfunc_t'(func_i);

  always_comb begin
    state_n  = state;
    op_n     = op;
    acc_n    = acc;
    opb_n    = opb;
    cnt_n    = cnt;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    dz_n     = dz;
    result_n = result_o;
    exc_n    = exc_o;
    busy_n   = busy_o;
    done_n   = 1'b0;
    sa       = int_signed(f) & a_i[31];
    sb       = int_signed(f) & b_i[31];
    sum      = {1'b0, acc[63:32]} + {1'b0, acc[0] ? opb : 32'd0};
    trial    = acc[63:31] - {1'b0, opb};
    prod     = neg_q ? 64'd0 - acc : acc;
    quo      = neg_q ? 32'd0 - acc[31:0] : acc[31:0];
    rem      = neg_r ? 32'd0 - acc[63:32] : acc[63:32];
    unique case (state)
      IDLE: begin
        if (start_i) begin
          if (int_iter(f)) begin
            op_n    = f;
            acc_n   = {32'd0, sa ? 32'd0 - a_i : a_i};
            opb_n   = sb ? 32'd0 - b_i : b_i;
            neg_q_n = sa ^ sb;
            neg_r_n = sa;
            dz_n    = (b_i == 32'd0);
            cnt_n   = 5'(INT_ITERS - 1);
            busy_n  = 1'b1;
            state_n = ITER;
          end else begin
            result_n = unary(f, a_i);
            exc_n    = 1'b0;
            done_n   = 1'b1;
          end
        end
      end
      ITER: begin
        if (int_mul(op)) begin
          acc_n = {sum, acc[31:1]};
        end else if (!trial[32]) begin
          acc_n = {trial[31:0], acc[30:0], 1'b1};
        end else begin
          acc_n = {acc[62:0], 1'b0};
        end
        cnt_n = cnt - 5'd1;
        if (cnt == 5'd0) state_n = FIX;
      end
      FIX: begin
        unique case (op)
          INT_MUL, INT_MULU:   result_n = prod[31:0];
          INT_MULX, INT_MULUX: result_n = prod[63:32];
          INT_DIV, INT_DIVU:   result_n = dz ? 32'hFFFF_FFFF : quo;
          INT_MOD, INT_MODU:   result_n = rem;
          default:             result_n = 32'd0;
        endcase
        // A zero divisor leaves |A| in the remainder half naturally.
        exc_n   = dz & ~int_mul(op);
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      op       <= INT_MUL;
      acc      <= 64'd0;
      opb      <= 32'd0;
      cnt      <= 5'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      result_o <= 32'd0;
      done_o   <= 1'b0;
      busy_o   <= 1'b0;
      exc_o    <= 1'b0;
    end else begin
      state    <= state_n;
      op       <= op_n;
      acc      <= acc_n;
      opb      <= opb_n;
      cnt      <= cnt_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      dz       <= dz_n;
      result_o <= result_n;
      done_o   <= done_n;
      busy_o   <= busy_n;
      exc_o    <= exc_n;
    end
  end

endmodule

// File: tb/tb_bexkat2_intunit.sv
// Directed vector bench for bexkat2_intunit: results, flags,
// latency, busy window, collisions, reset abort, back-to-back.
module tb_bexkat2_intunit;
  import bexkat1Def::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  func = 4'd0;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;
  logic [31:0] result;
  logic        done, busy, exc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bexkat2_intunit dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .func_i(func), .a_i(opa), .b_i(opb),
    .result_o(result), .done_o(done),
    .busy_o(busy), .exc_o(exc)
  );

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        x;
    int          k;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // k counts falling-edge samples after the accepting edge until
  // done_o is seen: 1 for unary, 34 (FIX at edge N+33) for iterative.
  task automatic do_op(input string nm, input logic [3:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic x,
                       input int k, input int poke);
    int n, bc;
    logic got;
    @(negedge clk);
    start = 1'b1; func = f; opa = a; opb = b;
    @(posedge clk);
    n = 0; bc = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (poke != 0 && n == poke) begin
        start = 1'b1; func = INT_MUL; opa = 32'd3; opb = 32'd3;
      end
      if (busy) bc++;
      if (done) got = 1'b1;
    end
    chk({nm, " done"}, 32'(got), 32'd1);
    chk({nm, " wait"}, n, k);
    chk({nm, " result"}, result, r);
    chk({nm, " exc"}, 32'(exc), 32'(x));
    chk({nm, " busy cycles"}, bc, (k == 1) ? 0 : 33);
    @(negedge clk);
    chk({nm, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{INT_MUL,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34};
    vecs[1]  = '{INT_MULX,  32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 34};
    vecs[2]  = '{INT_MULUX, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34};
    vecs[3]  = '{INT_MULU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 34};
    vecs[4]  = '{INT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 34};
    vecs[5]  = '{INT_MOD,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 34};
    vecs[6]  = '{INT_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 1'b0, 34};
    vecs[7]  = '{INT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 34};
    vecs[8]  = '{INT_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 34};
    vecs[9]  = '{INT_MODU,  32'd5,        32'd0,        32'h00000005, 1'b1, 34};
    vecs[10] = '{INT_EXTB,  32'h000000F0, 32'd0,        32'hFFFFFFF0, 1'b0, 1};
    vecs[11] = '{INT_EXT,   32'h00007FFF, 32'd0,        32'h00007FFF, 1'b0, 1};
    vecs[12] = '{INT_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFFF, 1'b1, 34};
    vecs[13] = '{INT_NEG,   32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 1};
    vecs[14] = '{INT_MOD,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 1'b1, 34};
    vecs[15] = '{INT_COM,   32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1};
    vecs[16] = '{INT_MODU,  32'd17,       32'd5,        32'h00000002, 1'b0, 34};
    vecs[17] = '{INT_DIVU,  32'd0,        32'd0,        32'hFFFFFFFF, 1'b1, 34};
    vecs[18] = '{4'd13,     32'h12345678, 32'd9,        32'h00000000, 1'b0, 1};

    repeat (2) @(negedge clk);
    chk("reset result", result, 32'd0);
    chk("reset flags", {29'd0, done, busy, exc}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
            vecs[i].r, vecs[i].x, vecs[i].k, 0);

    do_op("collide", INT_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34, 5);

    // abandon a DIV at ITER step 10
    @(negedge clk);
    start = 1'b1; func = INT_DIV; opa = 32'd1000; opb = 32'd3;
    @(posedge clk);
    repeat (11) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("rst result", result, 32'd0);
    chk("rst flags", {29'd0, done, busy, exc}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("rst no done", seen, 0);
    end
    do_op("mul after rst", INT_MUL, 32'd3, 32'd4, 32'h0000000C,
          1'b0, 34, 0);

    // back-to-back: issue NEG in the done_o cycle of a MUL
    @(negedge clk);
    start = 1'b1; func = INT_MUL; opa = 32'd6; opb = 32'd7;
    @(posedge clk);
    repeat (34) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("b2b mul done", 32'(done), 32'd1);
    chk("b2b mul result", result, 32'd42);
    start = 1'b1; func = INT_NEG; opa = 32'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b neg done", 32'(done), 32'd1);
    chk("b2b neg result", result, 32'hFFFFFFFF);
    chk("b2b neg busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bexkat2_intunit.md
# bexkat2_intunit

Iterative integer multiply/divide/modulo unit for the bexkat2 datapath. It executes every `intfunc_t` operation issued by the control unit's S_INT/S_INT2/S_INT3 sequence. Unary operations (EXT/EXTB/COM/NEG) complete in one cycle. MUL/DIV/MOD variants use a 32-step shift-add or shift-subtract engine with a start/done handshake. The result feeds the register-file write mux.

## Interface
Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  request; accepted only when busy_o=0.
- func_i  in  4  operation, `intfunc_t` encoding.
- a_i  in  32  operand A; the only operand for unary ops.
- b_i  in  32  operand B, already muxed by the INT2_B/INT2_SVAL select.
- result_o  out  32  registered result; holds until the next completion.
- done_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high while an iterative op is in flight.
- exc_o  out  1  divide-by-zero flag; valid with done_o and held with result_o.

## Operation
- Reset values: result_o=0, done_o=0, busy_o=0, exc_o=0, state=IDLE, iteration counter=0.
- States:
  - IDLE: waits for a request.
  - ITER: 32 steps, counter runs 31 down to 0.
  - FIX: sign correction and result registration.
- IDLE with start_i=1:
  - Unary and undefined ops: result and done_o are registered directly and the state stays IDLE.
  - MUL/DIV variants: magnitudes |A| and |B| (or raw values for unsigned ops) are latched, operand signs recorded, state goes to ITER.
- Function semantics:
  - MUL/MULU: low 32 bits of the product.
  - MULX: high 32 bits of the signed 64-bit product.
  - MULUX: high 32 bits of the unsigned product.
  - DIV/DIVU: truncating quotient.
  - MOD/MODU: remainder; sign of the remainder follows A.
  - EXT: sign-extend a_i[15:0]. EXTB: sign-extend a_i[7:0].
  - COM: ~a_i. NEG: 0-a_i.
  - func_i codes 12-15: result 0, exc_o=0.
- Datapath: one 64-bit accumulator plus a 32-bit operand register.
  - Multiply: add B if the LSB is set, then shift right.
  - Divide: restoring; shift left, trial-subtract B, set the quotient bit.
- Signed results:
  - Multiply: 64-bit product negated in FIX when sign(A)^sign(B).
  - Divide: quotient negated when signs differ.
  - Modulo: remainder negated when A is negative.
- Divide by zero, all DIV/MOD variants, full latency:
  - Quotient = 0xFFFFFFFF; remainder = a_i; exc_o=1.
- 0x80000000 / 0xFFFFFFFF (DIV) gives 0x80000000 with remainder 0, exc_o=0.
- start_i while busy_o=1 is ignored; it is not queued.
- func_i, a_i and b_i are sampled only at the accepting edge.

## Timing
- A request is accepted at edge N.
- Unary/undefined ops: result_o valid and done_o=1 in the cycle after edge N (latency 1). busy_o never rises.
- Iterative ops:
  - busy_o=1 after edge N.
  - ITER occupies edges N+1..N+32.
  - FIX at edge N+33 registers result_o and exc_o, pulses done_o, clears busy_o, and returns to IDLE (latency 33).
- Back-to-back: a new start_i is accepted in the same cycle done_o is high.
- done_o is high for exactly one cycle per accepted request.
- rst_i mid-operation clears all state and outputs immediately. The abandoned op never signals done_o.

## Structure
- `intfunc_t` stays in the shared `bexkat1Def` package.
- Add `INT_ITERS = 32` to that package so the control unit can size its wait.
- The unit's state enum (IDLE, ITER, FIX) stays local to the module.
- No sub-module; the shared accumulator datapath is inline.

## Test plan
- MUL, 7 × 0xFFFFFFFD -> result_o=0xFFFFFFEB; done_o exactly 33 cycles after start; busy_o high for 33 cycles.
- MULX 0x80000000 × 0x80000000 -> 0x40000000. MULUX 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULU same operands -> 0x00000001.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. MOD same operands -> 0xFFFFFFFF. DIVU 0xFFFFFFFF / 16 -> 0x0FFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, exc_o=0.
- DIVU 5 / 0 -> 0xFFFFFFFF, exc_o=1. MODU 5 / 0 -> 0x00000005, exc_o=1; both at latency 33.
- Unary and collisions:
  - EXTB 0x000000F0 -> 0xFFFFFFF0; EXT 0x00007FFF -> 0x00007FFF; NEG 1 -> 0xFFFFFFFF; COM 0 -> 0xFFFFFFFF; all done at latency 1.
  - start_i during busy is ignored; the original result is unchanged.
- Reset and back-to-back:
  - rst_i pulsed at ITER step 10 of a DIV -> all outputs 0, no done_o.
  - A following MUL 3×4 -> 0x0000000C at latency 33.
  - A new start in the done_o cycle is accepted.
